// File: rtl/bram_stream_readout.sv
// bram_stream_readout: streams a window of BRAM words out of an 8N1 UART.
// A start pulse latches base/count. An optional sync byte is sent first,
// then each word is fetched and serialized byte by byte in the chosen order.
module bram_stream_readout #(
    parameter int         DATA_WIDTH   = 24,
    parameter int         DEPTH        = 76800,
    parameter int         READ_LATENCY = 2,
    parameter int         BAUD_RATE    = 3000000,
    parameter int         CLK_FREQ     = 100000000,
    parameter bit         MSB_FIRST    = 1'b1,
    parameter bit         SYNC_EN      = 1'b1,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    localparam int        AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [AW-1:0]         base_addr_in,
    input  logic [AW:0]           count_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [AW-1:0]         req_addr_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  uart_tx
);

    localparam int NBYTES = (DATA_WIDTH + 7) / 8;
    localparam int CPB    = CLK_FREQ / BAUD_RATE;
    localparam int CW     = $clog2(CPB);
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, SYNC, FETCH, LOAD, SEND, NEXT} state_t;

    state_t                  state, state_nx;
    logic [AW-1:0]           addr;
    logic [AW:0]             words_left;
    logic [2:0]              lat_cnt;
    logic [BW-1:0]           byte_idx;
    logic                    done_r;
    logic [NBYTES*8-1:0]     word_buf;
    logic [NBYTES*8-1:0]     data_ext;
    logic                    ser_active;
    logic                    tx_r;
    logic [CW-1:0]           baud_cnt;
    logic [3:0]              bit_cnt;
    logic [8:0]              ser_sh;
    logic                    ser_load;
    logic                    ser_done;
    logic                    last_byte;
    logic [7:0]              ser_byte;
    logic [7:0]              ser_data;

    assign last_byte = (byte_idx == BW'(NBYTES - 1));
    assign ser_done  = ser_active && (bit_cnt == 4'd9) && (baud_cnt == CW'(CPB - 1));

    // Zero-extend the BRAM word to a whole number of bytes.
    always_comb begin
        data_ext = '0;
        data_ext[DATA_WIDTH-1:0] = data_in;
    end

    // Pick the byte to load: the current index on a fresh launch, the next one
    // when chaining back-to-back off a frame that is just finishing.
    always_comb begin
        int k;
        int phys;
        k = ser_active ? int'(byte_idx) + 1 : int'(byte_idx);
        if (k > NBYTES - 1) k = NBYTES - 1;
        phys = MSB_FIRST ? (NBYTES - 1 - k) : k;
        ser_byte = word_buf[phys*8 +: 8];
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nx;
    end

    // Next-state logic and serializer launch requests; abort overrides all.
    always_comb begin
        state_nx = state;
        ser_load = 1'b0;
        ser_data = SYNC_BYTE;
        case (state)
            IDLE: begin
                if (start_in) begin
                    if (SYNC_EN) state_nx = SYNC;
                    else         state_nx = FETCH;
                end
            end
            SYNC: begin
                ser_load = !ser_active;
                if (ser_done) state_nx = FETCH;
            end
            FETCH: begin
                if (lat_cnt == 3'(READ_LATENCY - 1)) state_nx = LOAD;
            end
            LOAD: state_nx = SEND;
            SEND: begin
                ser_data = ser_byte;
                ser_load = !ser_active || (ser_done && !last_byte);
                if (ser_done && last_byte) state_nx = NEXT;
            end
            NEXT: begin
                if (words_left == (AW+1)'(1)) state_nx = IDLE;
                else                          state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
        if (abort_in) begin
            state_nx = IDLE;
            ser_load = 1'b0;
        end
    end

    // Address, word count, latency and byte counters, done pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr       <= '0;
            words_left <= '0;
            lat_cnt    <= '0;
            byte_idx   <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= (state == NEXT) && (words_left == (AW+1)'(1)) && !abort_in;
            if (state == IDLE && state_nx != IDLE) begin
                addr       <= base_addr_in;
                words_left <= (count_in == '0) ? DEPTH_W : count_in;
            end
            if (state == NEXT && state_nx == FETCH)
                addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            if (state == NEXT && !abort_in)
                words_left <= words_left - 1'b1;
            if (state == FETCH) lat_cnt <= lat_cnt + 1'b1;
            else                lat_cnt <= '0;
            if (state == LOAD)
                byte_idx <= '0;
            else if (state == SEND && ser_done && !last_byte && !abort_in)
                byte_idx <= byte_idx + 1'b1;
        end
    end

    // Word buffer and frame shifter; pure data, no reset needed.
    always_ff @(posedge clk_in) begin
        if (state == LOAD) word_buf <= data_ext;
        if (ser_load)
            ser_sh <= {1'b1, ser_data};
        else if (ser_active && baud_cnt == CW'(CPB - 1))
            ser_sh <= {1'b1, ser_sh[8:1]};
    end

    // 8N1 bit timing; the line is a register, forced high on abort.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ser_active <= 1'b0;
            tx_r       <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
        end else if (abort_in) begin
            ser_active <= 1'b0;
            tx_r       <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
        end else if (ser_load) begin
            ser_active <= 1'b1;
            tx_r       <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
        end else if (ser_active) begin
            if (baud_cnt == CW'(CPB - 1)) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    ser_active <= 1'b0;
                    tx_r       <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    tx_r    <= ser_sh[0];
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    assign req_addr_out = addr;
    assign busy_out     = (state != IDLE);
    assign done_out     = done_r;
    assign uart_tx      = tx_r;

endmodule

// File: tb/tb_bram_stream_readout.sv
// Bench for bram_stream_readout: two instances (24-bit MSB-first with sync on a
// 16-deep BRAM, 12-bit LSB-first without sync on a 12-deep BRAM), a BRAM
// latency model per instance, and a UART receiver that decodes the serial lines.
module tb_bram_stream_readout;

    localparam int CPB_A = 4;
    localparam int CPB_B = 3;

    logic        clk, rst_n;
    logic        start_a, abort_a, busy_a, done_a, tx_a;
    logic [3:0]  base_a, addr_a;
    logic [4:0]  count_a;
    logic [23:0] data_a, pa0, pa1;
    logic        start_b, abort_b, busy_b, done_b, tx_b;
    logic [3:0]  base_b, addr_b;
    logic [4:0]  count_b;
    logic [11:0] data_b, pb0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_a[$], rx_b[$], st_a[$], st_b[$], al_a[$], al_b[$];
    int dn_a = 0, dn_b = 0, ov_a = 0, ov_b = 0, m_fe = 0;
    int m_t [2];
    bit m_act [2];
    logic [7:0] m_sh [2];
    logic pbusy_a = 1'b0, pbusy_b = 1'b0;
    logic [3:0] paddr_a = '0, paddr_b = '0;
    int r0, s0, a0, d0;

    typedef struct {
        int w;
        int base;
        int cnt;
        int nbytes;
        int last_addr;
    } vec_t;
    vec_t vecs [7];

    bram_stream_readout #(
        .DATA_WIDTH(24), .DEPTH(16), .READ_LATENCY(2), .BAUD_RATE(1),
        .CLK_FREQ(4), .MSB_FIRST(1'b1), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5)
    ) u_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_a), .abort_in(abort_a),
        .base_addr_in(base_a), .count_in(count_a), .data_in(data_a),
        .req_addr_out(addr_a), .busy_out(busy_a), .done_out(done_a), .uart_tx(tx_a)
    );

    bram_stream_readout #(
        .DATA_WIDTH(12), .DEPTH(12), .READ_LATENCY(1), .BAUD_RATE(2),
        .CLK_FREQ(6), .MSB_FIRST(1'b0), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5)
    ) u_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .abort_in(abort_b),
        .base_addr_in(base_b), .count_in(count_b), .data_in(data_b),
        .req_addr_out(addr_b), .busy_out(busy_b), .done_out(done_b), .uart_tx(tx_b)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mem_a(input int a);
        return 24'h112233 + 24'(a) * 24'h333333;
    endfunction

    function automatic logic [11:0] mem_b(input int a);
        if (a == 5) return 12'hABC;
        return {4'(a), 8'(8'h10 + a)};
    endfunction

    // BRAM read ports with their respective latencies
    always @(posedge clk) begin
        pa0 <= mem_a(int'(addr_a));
        pa1 <= pa0;
        pb0 <= mem_b(int'(addr_b));
        cyc <= cyc + 1;
    end
    assign data_a = pa1;
    assign data_b = pb0;

    // UART receiver, done/busy and address bookkeeping, sampled on the falling edge
    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            logic tx;
            int   cpb;
            int   k;
            tx  = (w == 0) ? tx_a : tx_b;
            cpb = (w == 0) ? CPB_A : CPB_B;
            if (!rst_n) begin
                m_act[w] = 1'b0;
            end else if (!m_act[w]) begin
                if (!tx) begin
                    m_act[w] = 1'b1;
                    m_t[w] = 0;
                    if (w == 0) st_a.push_back(cyc); else st_b.push_back(cyc);
                end
            end else begin
                m_t[w] = m_t[w] + 1;
                if (m_t[w] % cpb == cpb / 2) begin
                    k = m_t[w] / cpb;
                    if (k >= 1 && k <= 8) begin
                        m_sh[w][k-1] = tx;
                    end else if (k == 9) begin
                        if (!tx) m_fe = m_fe + 1;
                        if (w == 0) rx_a.push_back(int'(m_sh[w]));
                        else        rx_b.push_back(int'(m_sh[w]));
                        m_act[w] = 1'b0;
                    end
                end
            end
        end
        if (busy_a && (!pbusy_a || addr_a != paddr_a)) al_a.push_back(int'(addr_a));
        if (busy_b && (!pbusy_b || addr_b != paddr_b)) al_b.push_back(int'(addr_b));
        pbusy_a = busy_a; paddr_a = addr_a;
        pbusy_b = busy_b; paddr_b = addr_b;
        if (done_a) dn_a = dn_a + 1;
        if (done_b) dn_b = dn_b + 1;
        if (done_a && busy_a) ov_a = ov_a + 1;
        if (done_b && busy_b) ov_b = ov_b + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // sel: 0 = received bytes, 1 = frame start cycles, 2 = address log
    function automatic int q_size(input int w, input int sel);
        if (sel == 0) return (w == 0) ? rx_a.size() : rx_b.size();
        if (sel == 1) return (w == 0) ? st_a.size() : st_b.size();
        return (w == 0) ? al_a.size() : al_b.size();
    endfunction

    function automatic int q_get(input int w, input int sel, input int idx);
        if (idx < 0 || idx >= q_size(w, sel)) return -1;
        if (sel == 0) return (w == 0) ? rx_a[idx] : rx_b[idx];
        if (sel == 1) return (w == 0) ? st_a[idx] : st_b[idx];
        return (w == 0) ? al_a[idx] : al_b[idx];
    endfunction

    // Reference byte k of a dump starting at base
    function automatic int exp_byte(input int w, input int base, input int k);
        logic [23:0] va;
        logic [11:0] vb;
        int word, b;
        if (w == 0) begin
            if (k == 0) return 32'hA5;
            word = (k - 1) / 3;
            b    = (k - 1) % 3;
            va   = mem_a((base + word) % 16);
            return int'(va[8*(2-b) +: 8]);
        end
        word = k / 2;
        b    = k % 2;
        vb   = mem_b((base + word) % 12);
        return (b == 0) ? int'(vb[7:0]) : int'(vb[11:8]);
    endfunction

    task automatic mark(input int w);
        r0 = q_size(w, 0);
        s0 = q_size(w, 1);
        a0 = q_size(w, 2);
        d0 = (w == 0) ? dn_a : dn_b;
    endtask

    task automatic start_run(input int w, input int base, input int cnt);
        @(negedge clk);
        if (w == 0) begin base_a = 4'(base); count_a = 5'(cnt); start_a = 1'b1; end
        else        begin base_b = 4'(base); count_b = 5'(cnt); start_b = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check("busy_after_start", int'((w == 0) ? busy_a : busy_b), 1);
    endtask

    task automatic wait_idle(input int w, input int limit);
        int n = 0;
        while (((w == 0) ? busy_a : busy_b) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", int'(n < limit), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic verify(input int w, input int base, input int nbytes, input int last_addr);
        int bad, words, depth;
        depth = (w == 0) ? 16 : 12;
        words = (w == 0) ? (nbytes - 1) / 3 : nbytes / 2;
        check("byte_count", q_size(w, 0) - r0, nbytes);
        bad = 0;
        for (int k = 0; k < nbytes; k++)
            if (q_get(w, 0, r0 + k) != exp_byte(w, base, k)) bad++;
        check("byte_stream_errors", bad, 0);
        check("addr_log_len", q_size(w, 2) - a0, words);
        bad = 0;
        for (int k = 0; k < words; k++)
            if (q_get(w, 2, a0 + k) != (base + k) % depth) bad++;
        check("addr_sequence_errors", bad, 0);
        check("final_req_addr", int'((w == 0) ? addr_a : addr_b), last_addr);
        check("done_pulses", ((w == 0) ? dn_a : dn_b) - d0, 1);
        check("busy_after_done", int'((w == 0) ? busy_a : busy_b), 0);
    endtask

    initial begin
        int t1 [7];
        int runs [5];
        int n, len, gap;
        logic lvl;

        clk = 1'b0;
        rst_n = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; base_a = '0; count_a = '0;
        start_b = 1'b0; abort_b = 1'b0; base_b = '0; count_b = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_a", int'(tx_a), 1);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_done_a", int'(done_a), 0);
        check("rst_addr_a", int'(addr_a), 0);
        check("rst_tx_b", int'(tx_b), 1);
        check("rst_busy_b", int'(busy_b), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        //           w  base cnt nbytes last_addr
        vecs[0] = '{0,  0,   2,  7,     1};
        vecs[1] = '{0,  14,  4,  13,    1};
        vecs[2] = '{0,  3,   0,  49,    2};
        vecs[3] = '{0,  15,  1,  4,     15};
        vecs[4] = '{1,  5,   1,  2,     5};
        vecs[5] = '{1,  10,  0,  24,    9};
        vecs[6] = '{1,  11,  2,  4,     0};
        t1 = '{32'hA5, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};

        for (int i = 0; i < 7; i++) begin
            mark(vecs[i].w);
            start_run(vecs[i].w, vecs[i].base, vecs[i].cnt);
            wait_idle(vecs[i].w, 6000);
            verify(vecs[i].w, vecs[i].base, vecs[i].nbytes, vecs[i].last_addr);
            if (i == 0) begin
                for (int k = 0; k < 7; k++)
                    check($sformatf("t1_byte%0d", k), q_get(0, 0, r0 + k), t1[k]);
                check("frame_len_intra_word_1", q_get(0, 1, s0 + 2) - q_get(0, 1, s0 + 1), 10 * CPB_A);
                check("frame_len_intra_word_2", q_get(0, 1, s0 + 3) - q_get(0, 1, s0 + 2), 10 * CPB_A);
                gap = q_get(0, 1, s0 + 4) - q_get(0, 1, s0 + 3);
                check("inter_word_gap_bounded", int'(gap >= 10 * CPB_A && gap <= 10 * CPB_A + 5), 1);
            end
            if (i == 4) begin
                check("t2_byte0", q_get(1, 0, r0), 32'hBC);
                check("t2_byte1", q_get(1, 0, r0 + 1), 32'h0A);
            end
        end

        // Bit widths on the sync frame (A5: 0,1,0,1,00,...), then start while busy
        mark(0);
        start_run(0, 0, 1);
        n = 0;
        while (tx_a && n < 200) begin @(negedge clk); n++; end
        for (int j = 0; j < 5; j++) begin
            lvl = tx_a;
            len = 0;
            while (tx_a == lvl && len < 100) begin @(negedge clk); len++; end
            runs[j] = len;
        end
        check("start_bit_width", runs[0], CPB_A);
        check("d0_width", runs[1], CPB_A);
        check("d1_width", runs[2], CPB_A);
        check("d2_width", runs[3], CPB_A);
        check("d3_d4_width", runs[4], 2 * CPB_A);
        base_a = 4'd7; count_a = 5'd5; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle(0, 2000);
        verify(0, 0, 4, 0);

        // Abort in the middle of the third frame
        mark(0);
        start_run(0, 0, 2);
        n = 0;
        while (q_size(0, 1) < s0 + 3 && n < 1000) begin @(negedge clk); n++; end
        check("third_frame_started", int'(n < 1000), 1);
        repeat (5) @(negedge clk);
        check("tx_low_before_abort", int'(tx_a), 0);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check("abort_tx_high", int'(tx_a), 1);
        check("abort_busy_low", int'(busy_a), 0);
        repeat (60) @(negedge clk);
        check("abort_no_done", dn_a - d0, 0);
        check("abort_stays_idle", int'(busy_a), 0);
        mark(0);
        start_run(0, 1, 1);
        wait_idle(0, 2000);
        verify(0, 1, 4, 1);

        // Abort and start in the same idle cycle: abort wins
        @(negedge clk);
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        check("abort_beats_start", int'(busy_a), 0);

        // Reset in the middle of a dump
        mark(0);
        start_run(0, 9, 2);
        repeat (30) @(negedge clk);
        check("busy_before_reset", int'(busy_a), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", int'(tx_a), 1);
        check("midrst_busy", int'(busy_a), 0);
        check("midrst_done", int'(done_a), 0);
        check("midrst_addr", int'(addr_a), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("midrst_no_done", dn_a - d0, 0);

        check("done_while_busy", ov_a + ov_b, 0);
        check("framing_errors", m_fe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
